// File: rtl/calc_pkg.sv
// Shared definitions for the 16-bit signed calculator controller.
//   key_e     : keypad event codes; codes 16-31 are outside the enum and are
//               acknowledged and ignored by the sequencer.
//   AluOp*    : operation codes driven on AluOp.
//   state_e   : sequencer states.
//   MAG_LIMIT : largest operand magnitude accepted during digit entry.
package calc_pkg;

  typedef enum logic [4:0] {
    Key0   = 5'd0,
    Key1   = 5'd1,
    Key2   = 5'd2,
    Key3   = 5'd3,
    Key4   = 5'd4,
    Key5   = 5'd5,
    Key6   = 5'd6,
    Key7   = 5'd7,
    Key8   = 5'd8,
    Key9   = 5'd9,
    KeyAdd = 5'd10,
    KeySub = 5'd11,
    KeyMul = 5'd12,
    KeyNeg = 5'd13,
    KeyEq  = 5'd14,
    KeyClr = 5'd15
  } key_e;

  localparam logic [2:0] AluOpAdd = 3'b010;
  localparam logic [2:0] AluOpSub = 3'b011;
  localparam logic [2:0] AluOpMul = 3'b100;

  typedef enum logic [2:0] {
    StEntryA,
    StEntryB,
    StExecute,
    StResult,
    StError
  } state_e;

  localparam int unsigned MAG_LIMIT = 32767;

  function automatic logic is_digit(input logic [4:0] code);
    return code <= 5'd9;
  endfunction

  function automatic logic is_operator(input logic [4:0] code);
    return (code == KeyAdd) || (code == KeySub) || (code == KeyMul);
  endfunction

  function automatic logic [2:0] key_to_op(input logic [4:0] code);
    logic [2:0] op;
    op = AluOpAdd;
    if (code == KeySub) op = AluOpSub;
    if (code == KeyMul) op = AluOpMul;
    return op;
  endfunction

endpackage

// File: rtl/operand_accum.sv
// Decimal operand accumulator: unsigned magnitude, sign flag and digit count.
//   Clock, Reset : clock and asynchronous active-low reset
//   clr          : clear operand (applied before a same-cycle digit)
//   digit_en     : append digit; dropped if the count is full or the new
//                  magnitude would exceed MAG_LIMIT
//   digit        : decimal digit value 0-9
//   neg_toggle   : invert the sign flag
//   count        : number of accepted digits
//   value        : two's complement signed operand
module operand_accum
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 5,
  parameter int unsigned CntW       = $clog2(MAX_DIGITS + 1)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            clr,
  input  logic            digit_en,
  input  logic [3:0]      digit,
  input  logic            neg_toggle,
  output logic [CntW-1:0] count,
  output logic [15:0]     value
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_DIGITS);

  logic [15:0]     mag_q, mag_d, mag_base;
  logic            neg_q, neg_d, neg_base;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_base;
  logic [19:0]     prod;

  always_comb begin
    mag_base = clr ? 16'd0 : mag_q;
    neg_base = clr ? 1'b0 : neg_q;
    cnt_base = clr ? '0 : cnt_q;
    // Worst case 32767*10+9 fits comfortably in 20 bits.
    prod     = {4'd0, mag_base} * 20'd10 + {16'd0, digit};
    mag_d    = mag_base;
    neg_d    = neg_base;
    cnt_d    = cnt_base;
    if (neg_toggle) neg_d = ~neg_base;
    if (digit_en && (cnt_base != MaxCnt) && (prod <= 20'(MAG_LIMIT))) begin
      mag_d = prod[15:0];
      cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mag_q <= 16'd0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mag_q <= mag_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign value = neg_q ? (~mag_q + 16'd1) : mag_q;

endmodule

// File: rtl/calc_sequencer.sv
// Central controller of the 16-bit signed calculator.
// Takes keypad events over a KeyRdy/KeyRd handshake, builds operands A and B,
// runs one ALU operation per equals key over AluStart/AluDone and drives the
// display path.
//   Clock, Reset            : clock, asynchronous active-low reset
//   KeyRdy, KeyCode, KeyRd  : keypad event in, one-cycle acknowledge out
//   AluStart, AluOpA/B, AluOp : ALU request; operands held until AluDone
//   AluDone, AluResult, AluOvf: ALU completion
//   DisplayValue, DisplayValid: value shown to the user
//   Error                   : sticky error, cleared only by the CLR key
// Build option: define CALC_CHAIN_RESULT_EN to let an operator key in the
// result state reuse the result as operand A.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS  = 5,
  parameter int unsigned ALU_TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        KeyRdy,
  input  logic [4:0]  KeyCode,
  output logic        KeyRd,
  output logic        AluStart,
  output logic [15:0] AluOpA,
  output logic [15:0] AluOpB,
  output logic [2:0]  AluOp,
  input  logic        AluDone,
  input  logic [15:0] AluResult,
  input  logic        AluOvf,
  output logic [15:0] DisplayValue,
  output logic        DisplayValid,
  output logic        Error
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TmoW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(ALU_TIMEOUT);

  state_e          state_q, state_d;
  logic            key_rd_q;
  logic [15:0]     opa_q, opa_d;
  logic [2:0]      pend_q, pend_d;
  logic [15:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            start_q, start_d;
  logic [15:0]     result_q, result_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic            take;
  logic            key_dig, key_op, key_neg, key_eq, key_clr;
  logic            clear_all;
  logic            acc_clr, acc_dig, acc_neg;
  logic [CntW-1:0] acc_cnt;
  logic [15:0]     acc_value;

  assign key_dig = is_digit(KeyCode);
  assign key_op  = is_operator(KeyCode);
  assign key_neg = (KeyCode == KeyNeg);
  assign key_eq  = (KeyCode == KeyEq);
  assign key_clr = (KeyCode == KeyClr);

  // The cycle KeyRd is high the producer has not yet dropped KeyRdy, so the
  // key must not be taken a second time.
  assign take = KeyRdy && !key_rd_q && (state_q != StExecute);

  operand_accum #(
    .MAX_DIGITS (MAX_DIGITS),
    .CntW       (CntW)
  ) u_operand_accum (
    .Clock      (Clock),
    .Reset      (Reset),
    .clr        (acc_clr),
    .digit_en   (acc_dig),
    .digit      (KeyCode[3:0]),
    .neg_toggle (acc_neg),
    .count      (acc_cnt),
    .value      (acc_value)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    pend_d    = pend_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    start_d   = 1'b0;
    result_d  = result_q;
    tmo_d     = tmo_q;
    clear_all = 1'b0;
    acc_clr   = 1'b0;
    acc_dig   = 1'b0;
    acc_neg   = 1'b0;

    unique case (state_q)
      StEntryA: begin
        if (take) begin
          if (key_dig) begin
            acc_dig = 1'b1;
          end else if (key_neg) begin
            acc_neg = 1'b1;
          end else if (key_op) begin
            opa_d   = acc_value;
            pend_d  = key_to_op(KeyCode);
            acc_clr = 1'b1;
            state_d = StEntryB;
          end else if (key_clr) begin
            clear_all = 1'b1;
          end
        end
      end
      StEntryB: begin
        if (take) begin
          if (key_dig) begin
            acc_dig = 1'b1;
          end else if (key_neg) begin
            acc_neg = 1'b1;
          end else if (key_op) begin
            // Operator before any B digit means the user changed their mind.
            if (acc_cnt == '0) pend_d = key_to_op(KeyCode);
          end else if (key_eq) begin
            if (acc_cnt != '0) begin
              alu_a_d  = opa_q;
              alu_b_d  = acc_value;
              alu_op_d = pend_q;
              start_d  = 1'b1;
              tmo_d    = '0;
              acc_clr  = 1'b1;
              state_d  = StExecute;
            end
          end else if (key_clr) begin
            clear_all = 1'b1;
          end
        end
      end
      StExecute: begin
        tmo_d = tmo_q + 1'b1;
        if (AluDone) begin
          if (AluOvf) begin
            state_d = StError;
          end else begin
            result_d = AluResult;
            state_d  = StResult;
          end
        end else if (tmo_d == TmoLimit) begin
          state_d = StError;
        end
      end
      StResult: begin
        if (take) begin
          if (key_dig) begin
            // Starts a fresh A operand with this digit as its first digit.
            acc_clr = 1'b1;
            acc_dig = 1'b1;
            state_d = StEntryA;
          end else if (key_clr) begin
            clear_all = 1'b1;
          end else if (key_op) begin
`ifdef CALC_CHAIN_RESULT_EN
            opa_d   = result_q;
            pend_d  = key_to_op(KeyCode);
            acc_clr = 1'b1;
            state_d = StEntryB;
`endif
          end
        end
      end
      StError: begin
        if (take && key_clr) clear_all = 1'b1;
      end
      default: state_d = StEntryA;
    endcase

    if (clear_all) begin
      state_d = StEntryA;
      opa_d   = 16'd0;
      pend_d  = AluOpAdd;
      acc_clr = 1'b1;
      acc_dig = 1'b0;
      acc_neg = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StEntryA;
      key_rd_q <= 1'b0;
      opa_q    <= 16'd0;
      pend_q   <= AluOpAdd;
      alu_a_q  <= 16'd0;
      alu_b_q  <= 16'd0;
      alu_op_q <= 3'd0;
      start_q  <= 1'b0;
      result_q <= 16'd0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      key_rd_q <= take;
      opa_q    <= opa_d;
      pend_q   <= pend_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      start_q  <= start_d;
      result_q <= result_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    DisplayValue = 16'd0;
    unique case (state_q)
      StEntryA, StEntryB: DisplayValue = acc_value;
      StResult:           DisplayValue = result_q;
      default:            DisplayValue = 16'd0;
    endcase
  end

  assign KeyRd        = key_rd_q;
  assign AluStart     = start_q;
  assign AluOpA       = alu_a_q;
  assign AluOpB       = alu_b_q;
  assign AluOp        = alu_op_q;
  assign DisplayValid = (state_q != StExecute);
  assign Error        = (state_q == StError);

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Central controller of the 16-bit signed calculator.
- Consumes decoded keypad events through a ready/read handshake and builds two signed decimal operands from digit keys.
- Latches the pending operator, sequences one ALU operation per equals key with a start/done handshake, and presents the current operand or result to the display path.
- Sits between the keypad input controller and the arithmetic unit / display driver.

Parameters:
- MAX_DIGITS, 5, maximum decimal digits accepted per operand.
- ALU_TIMEOUT, 255, cycles waited for AluDone before entering ERROR.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- KeyRdy  in  1  key event valid; held high by producer until KeyRd.
- KeyCode  in  5  key event code; encoding in package.
- KeyRd  out  1  one-cycle acknowledge; key consumed.
- AluStart  out  1  one-cycle request to ALU.
- AluOpA  out  16  signed operand A; stable from AluStart until AluDone.
- AluOpB  out  16  signed operand B; same stability rule.
- AluOp  out  3  operation: 3'b010 add, 3'b011 sub, 3'b100 mul.
- AluDone  in  1  one-cycle ALU completion.
- AluResult  in  16  signed result, valid with AluDone.
- AluOvf  in  1  overflow, valid with AluDone.
- DisplayValue  out  16  signed value to show.
- DisplayValid  out  1  DisplayValue meaningful.
- Error  out  1  sticky error indicator.

Behaviour:
- Reset (async, Reset=0):
  - State ENTRY_A; operand magnitude, sign, digit count and OpA cleared.
  - Pending op = add.
  - KeyRd=0, AluStart=0, AluOpA/B/Op=0, DisplayValue=0, DisplayValid=1, Error=0.
  - Reset during EXECUTE aborts the operation with no further AluStart.
- Key handshake:
  - In an accepting state with KeyRdy=1, the key is processed that cycle and KeyRd=1 registered for exactly one cycle.
  - The cycle after KeyRd, KeyRdy is ignored, so a key is never processed twice.
  - In EXECUTE, KeyRd stays 0 and the producer stalls.
  - Every key processed in an accepting state is acknowledged, including ignored keys.
- Operand entry:
  - Operand = unsigned magnitude Mag[15:0] plus sign bit Neg plus digit count.
  - Digit d: Mag <= Mag*10+d, computed at 20 bits.
  - The digit is ignored if the product exceeds 32767 or count == MAX_DIGITS.
  - NEG key toggles Neg.
  - Signed operand = Neg ? -Mag : Mag.
- States:
  - ENTRY_A:
    - Digit / NEG: update operand.
    - ADD/SUB/MUL: latch signed operand into OpA, store op, clear operand, go to ENTRY_B.
    - EQ: ignored.
    - CLR: clear everything.
  - ENTRY_B:
    - Digit / NEG: update operand.
    - Operator with count=0: replaces pending op.
    - Operator with count>0: ignored.
    - EQ with count>0: go to EXECUTE.
    - EQ with count=0: ignored.
    - CLR: go to ENTRY_A, cleared.
  - EXECUTE:
    - AluStart=1 in the first cycle only; DisplayValid=0.
    - Timeout counter increments each cycle.
    - AluDone with AluOvf=0: latch AluResult, go to RESULT.
    - AluDone with AluOvf=1: go to ERROR.
    - Counter == ALU_TIMEOUT without AluDone: go to ERROR.
    - AluDone and timeout in the same cycle: AluDone wins.
  - RESULT:
    - DisplayValue = result.
    - Digit: clear, go to ENTRY_A with that digit applied.
    - CLR: go to ENTRY_A, cleared.
    - NEG / EQ: ignored.
    - Operator: see optional feature.
  - ERROR:
    - Error=1, DisplayValue=0.
    - Only CLR exits, to ENTRY_A with Error=0.
- AluDone outside EXECUTE is ignored.
- DisplayValue in ENTRY_A/ENTRY_B = current signed operand, updated the cycle after the key is processed.

Optional Feature:
- CALC_CHAIN_RESULT_EN
  - Defined: operator key in RESULT loads the result into OpA, stores the op, and enters ENTRY_B.
  - Undefined: operator key in RESULT is acknowledged and ignored.

Decomposition:
- Package calc_pkg holds:
  - key-code enum: 0–9 digits, 10 ADD, 11 SUB, 12 MUL, 13 NEG, 14 EQ, 15 CLR; codes 16–31 acknowledged and ignored.
  - ALU op constants, matching the AluOp encoding above.
  - State enum.
  - MAG_LIMIT = 32767.
- Sub-module operand_accum: magnitude/sign/digit-count register with digit, negate and clear controls, and signed output.

Test Plan:
- Keys 1,2,ADD,3,4,EQ; ALU returns 46 after 3 cycles -> AluStart once with OpA=12, OpB=34, AluOp=3'b010; DisplayValue=46; six KeyRd pulses.
- Digits 3,2,7,6,8,9 -> Mag stops at 32768? No: 3276 accepted, 8 rejected (32768>32767), 9 rejected; DisplayValue=3276; all six acknowledged.
- Keys 5,NEG,MUL,SUB,2,EQ -> OpA=-5, AluOp=3'b011, OpB=2.
- EQ then AluDone held low 255 cycles -> ERROR, Error=1; digit key acknowledged with no change; CLR -> Error=0, DisplayValue=0.
- AluDone with AluOvf=1 -> ERROR. Reset asserted mid-EXECUTE -> all outputs at reset values, next key processed in ENTRY_A.
- After result 46, press ADD,4,EQ -> with CALC_CHAIN_RESULT_EN: OpA=46, OpB=4. Without it: ADD ignored; 4 starts a new ENTRY_A; EQ ignored.
